// File: rtl/h10_io_ctl_if.sv
// CPU command and HITAC-10 peripheral bus signals of the I/O channel controller.
// master = controller side, slave = CPU decoder / peripheral side.
interface h10_io_ctl_if;
  logic       cpu_req;
  logic       cpu_wr;
  logic [1:0] cpu_dev;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       cpu_perr;
  logic       cpu_err;
  logic       busy;
  logic [7:0] H_DIN;
  logic [7:0] H_DOUT;
  logic [3:0] H_DSEL;
  logic       H_DOPT;
  logic [3:0] H_DREQ;
  logic [3:0] H_DRDY;

  modport master (
    input  cpu_req, cpu_wr, cpu_dev, cpu_wdata, H_DIN, H_DRDY,
    output cpu_ack, cpu_rdata, cpu_perr, cpu_err, busy,
           H_DOUT, H_DSEL, H_DOPT, H_DREQ
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_dev, cpu_wdata, H_DIN, H_DRDY,
    input  cpu_ack, cpu_rdata, cpu_perr, cpu_err, busy,
           H_DOUT, H_DSEL, H_DOPT, H_DREQ
  );
endinterface

// File: rtl/h10_io_ctl.sv
// HITAC-10 I/O channel controller: one CPU command at a time, four-phase
// H_DREQ/H_DRDY handshake to device 0-3 with per-phase timeout.
module h10_io_ctl #(
  parameter int          TMO_W    = 16,
  parameter int unsigned TMO_MAX  = 16'hFFFF,
  parameter logic [3:0]  PAR_MASK = 4'b0001
) (
  input  logic          clk,
  input  logic          reset,
  h10_io_ctl_if.master  bus
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_REQ, S_REL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dev_q, dev_d;
  logic             wr_q, wr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             perr_q, perr_d;
  logic             err_q, err_d;
  logic [3:0]       sel;
  logic             rdy, tmo;

  assign sel = 4'b0001 << dev_q;
  assign rdy = bus.H_DRDY[dev_q];
  assign tmo = (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dev_d   = dev_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    perr_d  = perr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (bus.cpu_req) begin
        dev_d   = bus.cpu_dev;
        wr_d    = bus.cpu_wr;
        wdata_d = bus.cpu_wdata;
        rdata_d = '0;
        perr_d  = 1'b0;
        err_d   = 1'b0;
        // A ready left high by the previous transfer must fall before we request.
        state_d = bus.H_DRDY[bus.cpu_dev] ? S_PRE : S_REQ;
      end
      S_PRE: begin
        if (!rdy) state_d = S_REQ;
        else if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          perr_d  = 1'b0;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_REQ: begin
        if (rdy) begin
          if (!wr_q) begin
            rdata_d = bus.H_DIN;
            perr_d  = PAR_MASK[dev_q] & (^bus.H_DIN);
          end
          state_d = S_REL;
        end else if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          perr_d  = 1'b0;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_REL: begin
        // Byte already captured stays reported if the release never comes.
        if (!rdy) state_d = S_DONE;
        else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dev_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dev_q   <= dev_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cpu_ack   = (state_q == S_DONE);
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_perr  = perr_q;
  assign bus.cpu_err   = err_q;
  assign bus.H_DOUT    = wdata_q;
  assign bus.H_DSEL    = bus.busy ? sel : 4'b0000;
  assign bus.H_DOPT    = bus.busy & wr_q;
  assign bus.H_DREQ    = (state_q == S_REQ) ? sel : 4'b0000;
endmodule

// File: tb/tb_h10_io_ctl.sv
// Bench for h10_io_ctl: scripted peripheral plus timeline model of each
// command (ack cycle, returned byte, flags, request length).
module tb_h10_io_ctl;
  localparam logic [3:0] PMASK = 4'b0001;
  localparam int         TMO   = 16;

  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;

  h10_io_ctl_if bus();

  h10_io_ctl #(.TMO_W(8), .TMO_MAX(TMO), .PAR_MASK(PMASK)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] d);
    logic [3:0] v;
    v    = 4'b0000;
    v[d] = 1'b1;
    return v;
  endfunction

  // S: cycles the stale ready stays high after accept (0 = none)
  // L: cycles the device waits after seeing H_DREQ before raising ready
  // R: cycles the device waits after H_DREQ drops before dropping ready
  task automatic run_cmd(input string tag, input logic [1:0] dev, input logic wr,
                         input logic [7:0] wdata, input logic [7:0] din,
                         input int S, input int L, input int R);
    int a, b, c, exp_hi, hi, lo, nhi, ack_k;
    logic req_to, rel_to, raised, dropped, acked, prot_ok, pre_ok;
    logic [7:0] e_rdata;
    logic e_perr, e_err;
    logic [31:0] obs_ack;

    // reference: request window opens at edge S, each phase bounded by TMO cycles
    a = S;
    b = 0;
    rel_to = 1'b0;
    req_to = (L >= TMO);
    if (req_to) begin
      c = a + TMO;
      exp_hi = TMO;
    end else begin
      b = a + 1 + L;
      exp_hi = L + 1;
      rel_to = (R >= TMO);
      c = rel_to ? b + TMO : b + 1 + R;
    end
    e_err   = req_to | rel_to;
    e_rdata = (wr || req_to) ? 8'h00 : din;
    e_perr  = !wr && !req_to && PMASK[dev] && (^din);

    bus.cpu_req   = 1'b1;
    bus.cpu_dev   = dev;
    bus.cpu_wr    = wr;
    bus.cpu_wdata = wdata;
    bus.H_DIN     = din;
    bus.H_DRDY    = (S > 0) ? oh(dev) : 4'b0000;
    hi = 0; lo = 0; nhi = 0; ack_k = -1;
    raised = 1'b0; dropped = 1'b0; acked = 1'b0; prot_ok = 1'b1; pre_ok = 1'b1;

    @(posedge clk);
    for (int k = 0; k < 80 && !acked; k++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        acked = 1'b1;
        ack_k = k;
      end else begin
        if (!bus.busy || bus.H_DSEL !== oh(dev) || bus.H_DOPT !== wr ||
            (bus.H_DREQ & ~oh(dev)) !== 4'b0000) prot_ok = 1'b0;
        if (wr && bus.H_DOUT !== wdata) prot_ok = 1'b0;
        if (k < S && bus.H_DREQ !== 4'b0000) pre_ok = 1'b0;
        if (bus.H_DREQ[dev]) nhi++;
        if (S > 0 && k + 1 == S) bus.H_DRDY = 4'b0000;
        if (bus.H_DREQ[dev]) begin
          hi++;
          if (!raised && hi > L) begin
            bus.H_DRDY = oh(dev);
            raised = 1'b1;
          end
        end else if (raised && !dropped) begin
          lo++;
          if (lo > R) begin
            bus.H_DRDY = 4'b0000;
            dropped = 1'b1;
          end
        end
        // noise on the command port while busy must be ignored
        bus.cpu_req   = 1'($urandom_range(0, 1));
        bus.cpu_dev   = 2'($urandom);
        bus.cpu_wr    = 1'($urandom);
        bus.cpu_wdata = 8'($urandom);
      end
    end
    bus.cpu_req = 1'b0;

    obs_ack = 32'(ack_k);
    check({tag, " ack_cycle"}, obs_ack, 32'(c));
    check({tag, " rdata"},     32'(bus.cpu_rdata), 32'(e_rdata));
    check({tag, " perr"},      32'(bus.cpu_perr), 32'(e_perr));
    check({tag, " err"},       32'(bus.cpu_err), 32'(e_err));
    check({tag, " dreq_at_ack"}, 32'(bus.H_DREQ), 32'd0);
    check({tag, " bus_stable"}, 32'(prot_ok), 32'd1);
    check({tag, " pre_no_req"}, 32'(pre_ok), 32'd1);
    check({tag, " req_len"},   32'(nhi), 32'(exp_hi));
    @(negedge clk);
    check({tag, " ack_width"}, 32'({bus.cpu_ack, bus.busy, bus.H_DSEL, bus.H_DOPT}), 32'd0);
    bus.H_DRDY = 4'b0000;
  endtask

  initial begin
    logic        ack_seen;
    logic [1:0]  rdev;
    logic        rwr;
    logic [7:0]  rwd, rdin;
    int          rs, rl, rr;

    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_dev   = 2'd0;
    bus.cpu_wdata = 8'h00;
    bus.H_DIN     = 8'h00;
    bus.H_DRDY    = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({bus.cpu_ack, bus.cpu_rdata, bus.cpu_perr, bus.cpu_err, bus.busy,
          bus.H_DOUT, bus.H_DSEL, bus.H_DOPT, bus.H_DREQ}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset", 32'({bus.busy, bus.H_DREQ, bus.H_DSEL}), 32'd0);

    run_cmd("rd0 0x41 tape", 2'd0, 1'b0, 8'h00, 8'h41, 0, 8, 0);
    run_cmd("rd0 0x43 perr", 2'd0, 1'b0, 8'h00, 8'h43, 0, 2, 1);
    run_cmd("rd1 0x43 nomask", 2'd1, 1'b0, 8'h00, 8'h43, 0, 2, 1);
    run_cmd("wr2 0x5A", 2'd2, 1'b1, 8'h5A, 8'hFF, 0, 3, 2);
    run_cmd("min length", 2'd0, 1'b0, 8'h00, 8'h81, 0, 0, 0);
    run_cmd("rd3 timeout", 2'd3, 1'b0, 8'h00, 8'h41, 0, 99, 0);
    run_cmd("rd1 stale", 2'd1, 1'b0, 8'h00, 8'h7E, 5, 1, 0);
    run_cmd("rd0 rel timeout", 2'd0, 1'b0, 8'h00, 8'h43, 0, 0, 99);
    run_cmd("req edge L15", 2'd2, 1'b0, 8'h00, 8'h11, 0, 15, 0);

    // reset in the middle of a request
    bus.cpu_req   = 1'b1;
    bus.cpu_dev   = 2'd2;
    bus.cpu_wr    = 1'b0;
    bus.cpu_wdata = 8'hA5;
    bus.H_DRDY    = 4'b0000;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("mid req dreq", 32'(bus.H_DREQ), 32'h4);
    reset = 1'b1;
    #1;
    check("async reset outputs", 32'({bus.cpu_ack, bus.cpu_rdata, bus.cpu_perr, bus.cpu_err, bus.busy,
          bus.H_DOUT, bus.H_DSEL, bus.H_DOPT, bus.H_DREQ}), 32'd0);
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.cpu_ack) ack_seen = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    check("no ack after reset", 32'(ack_seen | bus.cpu_ack), 32'd0);
    run_cmd("rd2 after reset", 2'd2, 1'b0, 8'h00, 8'h3C, 0, 4, 1);

    for (int i = 0; i < 40; i++) begin
      rdev = 2'($urandom);
      rwr  = 1'($urandom);
      rwd  = 8'($urandom);
      rdin = 8'($urandom);
      rs   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      rl   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 12));
      rr   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 6));
      run_cmd($sformatf("rand%0d", i), rdev, rwr, rwd, rdin, rs, rl, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
